// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master slice.
//   spi_state_e : transfer FSM states
//   SPI_CPOL/SPI_CPHA : bus mode (mode 0: sclk idles low, capture on rising edge)
//   cnt_width() : width of a counter that must hold values 0..max_val
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER_HI,
    XFER_LO
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period tick generator for the SPI master.
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high; counter held at zero while low
//   clr        : synchronous restart of the count
//   tick       : one-cycle pulse on every CLK_DIV-th enabled cycle
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator, one WIDTH-bit word per transfer.
//   clk, rst_n     : system clock, async active-low reset
//   start, txData  : transfer request and word, taken when ready=1
//   ready          : idle, able to accept start
//   rxData/rxValid : received word and its one-cycle update strobe
//   sclk, cs_n     : serial clock (idles low) and active-low chip select
//   mosi, miso     : serial data out / in
// Build option: define SPI_LSB_FIRST_EN to shift LSB first (timing unchanged).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic             ready,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             accept, tick;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic tx_head(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic [WIDTH-1:0] tx_next(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]};
  endfunction
  function automatic logic [WIDTH-1:0] rx_next(input logic [WIDTH-1:0] v, input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction
`else
  function automatic logic tx_head(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] tx_next(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic [WIDTH-1:0] rx_next(input logic [WIDTH-1:0] v, input logic b);
    return {v[WIDTH-2:0], b};
  endfunction
`endif

  assign accept = start && ready_q;

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != IDLE),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    ready_d    = ready_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SETUP;
          tx_shift_d = txData;
          mosi_d     = tx_head(txData);
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          cs_n_d     = 1'b0;
          ready_d    = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d    = XFER_HI;
          sclk_d     = ~SPI_CPOL;
          rx_shift_d = rx_next(rx_shift_q, miso);
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      XFER_HI: begin
        if (tick) begin
          state_d = XFER_LO;
          sclk_d  = SPI_CPOL;
          // after the last bit mosi is left alone; the final low phase is CS hold
          if (bit_cnt_q != BIT_LAST) begin
            tx_shift_d = tx_next(tx_shift_q);
            mosi_d     = tx_head(tx_next(tx_shift_q));
          end
        end
      end
      XFER_LO: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = IDLE;
            cs_n_d     = 1'b1;
            ready_d    = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d    = XFER_HI;
            sclk_d     = ~SPI_CPOL;
            rx_shift_d = rx_next(rx_shift_q, miso);
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      sclk_q     <= SPI_CPOL;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign ready   = ready_q;
  assign rxData  = rx_data_q;
  assign rxValid = rx_valid_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned W = 8;
`ifdef SPI_LSB_FIRST_EN
  localparam int unsigned DIV = 1;
  localparam int DONE_LIT = 18;   // 1 + 1*(2*8+1)
  localparam int HOLD_LIT = 41;
  localparam int MID_LIT  = 10;
  localparam int RST_LIT  = 9;
`else
  localparam int unsigned DIV = 5;
  localparam int DONE_LIT = 86;   // 1 + 5*(2*8+1)
  localparam int HOLD_LIT = 200;
  localparam int MID_LIT  = 20;
  localparam int RST_LIT  = 40;
`endif
  localparam int TOT = DIV * (2 * W + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         ready, rx_valid, sclk, cs_n, mosi, miso;
  logic [W-1:0] rx_data;

  spi_master #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .txData (tx_data),
    .ready  (ready),
    .rxData (rx_data),
    .rxValid(rx_valid),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral shift register: loopback when periph_en=0.
  logic         periph_en = 1'b0;
  logic [W-1:0] p_preload = '0;
  logic [W-1:0] p_out = '0;
  logic [W-1:0] p_cap = '0;
  logic         cs_last = 1'b1;

`ifdef SPI_LSB_FIRST_EN
  assign miso = periph_en ? p_out[0] : mosi;
`else
  assign miso = periph_en ? p_out[W-1] : mosi;
`endif

  always @(negedge sclk or negedge cs_n or posedge cs_n) begin
    if (cs_n) cs_last = 1'b1;
    else if (cs_last) begin
      p_out   = p_preload;
      cs_last = 1'b0;
    end else begin
`ifdef SPI_LSB_FIRST_EN
      p_out = p_out >> 1;
`else
      p_out = p_out << 1;
`endif
    end
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
`ifdef SPI_LSB_FIRST_EN
      p_cap = {mosi, p_cap[W-1:1]};
`else
      p_cap = {p_cap[W-2:0], mosi};
`endif
    end
  end

  // Event monitor.
  int rv_count = 0;
  int last_rv_cyc = -1;
  int rises = 0;
  int sclk_idle = 0;
  int cs_falls[$];
  logic sclk_p = 1'b0;
  logic cs_p = 1'b1;
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_count++;
      last_rv_cyc = cyc;
    end
    if (sclk && !sclk_p) rises++;
    if (!cs_n && cs_p) cs_falls.push_back(cyc);
    if (sclk && cs_n) sclk_idle++;
    sclk_p = sclk;
    cs_p   = cs_n;
  end

  // Transaction-level model: every output follows from the accept cycle t0.
  int           m_t0 = -1;
  logic [W-1:0] m_tx = '0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_rxdata = '0;
  always @(negedge clk) begin
    int k, p, idx;
    bit act;
    if (!rst_n) begin
      m_t0 = -1;
      m_rxdata = '0;
      chk("rst_ready", ready, 1);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_rxvalid", rx_valid, 0);
      chk("rst_rxdata", rx_data, 0);
    end else begin
      k   = (m_t0 < 0) ? -1 : cyc - m_t0;
      act = (k >= 1) && (k <= TOT);
      p   = act ? (k - 1) / DIV : 0;
      if (k == TOT + 1) m_rxdata = m_word;
      chk("cs_n", cs_n, !act);
      chk("ready", ready, !act);
      chk("sclk", sclk, act && (p % 2 == 1));
      chk("rxvalid", rx_valid, k == TOT + 1);
      chk("rxdata", rx_data, m_rxdata);
      if (act) begin
        idx = p / 2;
        if (idx > W - 1) idx = W - 1;
`ifdef SPI_LSB_FIRST_EN
        chk("mosi", mosi, m_tx[idx]);
`else
        chk("mosi", mosi, m_tx[W-1-idx]);
`endif
      end
      if (!act && start) begin
        m_t0   = cyc;
        m_tx   = tx_data;
        m_word = periph_en ? p_preload : tx_data;
      end
    end
  end

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [W-1:0] d, output int t0);
    @(posedge clk);
    #1;
    start   = 1'b1;
    tx_data = d;
    t0      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int rv0, input string name);
    int n = 0;
    while (rv_count == rv0 && n < 4 * TOT + 20) begin
      @(posedge clk);
      n++;
    end
    if (rv_count == rv0) chk({name, "_timeout"}, 0, 1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rv0, r0, f0;

    repeat (3) @(posedge clk);
    #1;
    chk("init_cs_n", cs_n, 1);
    chk("init_ready", ready, 1);
    chk("init_rxdata", rx_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: loopback A5
    rv0 = rv_count; r0 = rises; f0 = cs_falls.size();
    do_start(8'hA5, t0);
    chk("t1_first_mosi", mosi, 1);
    wait_done(rv0, "t1");
    chk("t1_done_cyc", last_rv_cyc - t0, DONE_LIT);
    chk("t1_rxdata", rx_data, 8'hA5);
    chk("t1_rises", rises - r0, 8);
    chk("t1_cs_fall", cs_falls[f0] - t0, 1);

    // 2: peripheral preloaded 3C, send C3
    periph_en = 1'b1;
    p_preload = 8'h3C;
    rv0 = rv_count; r0 = rises;
    do_start(8'hC3, t0);
    wait_done(rv0, "t2");
    chk("t2_periph_cap", p_cap, 8'hC3);
    chk("t2_rxdata", rx_data, 8'h3C);
    chk("t2_rises", rises - r0, 8);
    periph_en = 1'b0;

    // 3: start held high
    rv0 = rv_count; f0 = cs_falls.size();
    @(posedge clk);
    #1;
    start = 1'b1;
    tx_data = 8'h96;
    t0 = cyc;
    go_to(t0 + HOLD_LIT);
    start = 1'b0;
    chk("t3_pulses_in_window", rv_count - rv0, 2);
    chk("t3_second_cs_fall", cs_falls[f0 + 1] - t0, DONE_LIT + 1);
    rv0 = rv_count;
    wait_done(rv0, "t3_tail");
    chk("t3_rxdata", rx_data, 8'h96);

    // 4: start mid-transfer ignored
    rv0 = rv_count;
    do_start(8'h69, t0);
    go_to(t0 + MID_LIT);
    start = 1'b1;
    tx_data = 8'hFF;
    chk("t4_ready_mid", ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(rv0, "t4");
    chk("t4_done_cyc", last_rv_cyc - t0, DONE_LIT);
    chk("t4_rxdata", rx_data, 8'h69);
    repeat (TOT + 5) @(posedge clk);
    #1;
    chk("t4_single_pulse", rv_count - rv0, 1);

    // 5: reset mid-transfer
    rv0 = rv_count;
    do_start(8'h33, t0);
    go_to(t0 + RST_LIT);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_cs_n_async", cs_n, 1);
    chk("t5_sclk_async", sclk, 0);
    chk("t5_ready_async", ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (TOT + 5) @(posedge clk);
    #1;
    chk("t5_no_pulse", rv_count - rv0, 0);
    chk("t5_rxdata_cleared", rx_data, 0);
    do_start(8'h5A, t0);
    wait_done(rv0, "t5");
    chk("t5_done_cyc", last_rv_cyc - t0, DONE_LIT);
    chk("t5_rxdata", rx_data, 8'h5A);

`ifdef SPI_LSB_FIRST_EN
    // 6: LSB first, word 01
    rv0 = rv_count;
    do_start(8'h01, t0);
    chk("t6_first_mosi", mosi, 1);
    wait_done(rv0, "t6");
    chk("t6_done_cyc", last_rv_cyc - t0, 18);
    chk("t6_rxdata", rx_data, 8'h01);
`endif

    chk("sclk_idle_toggles", sclk_idle, 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
